// File: rtl/tile_scroll_control.sv
// Game-state sequencer upstream of the erase/draw sequencer: owns tile rows, scroll offset, score and game-over.
// One update per frame tick; draw_go is held until drawing is done, then dropped for one cycle before the update.
module tile_scroll_control #(
  parameter int unsigned ROW_HEIGHT = 40,
  parameter int unsigned STEP       = 1,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        all_drawing_done,
  input  logic [3:0]  key_press,
  output logic        draw_go,
  output logic [5:0]  offset,
  output logic [17:0] lines,
  output logic [7:0]  score,
  output logic        game_over,
  output logic        frame_overrun
);
  typedef enum logic [2:0] {IDLE, ISSUE, RELEASE, UPDATE, OVER} state_t;

  state_t          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            tick_pending_q, tick_pending_d;
  logic            overrun_q, overrun_d;
  logic            key_pending_q, key_pending_d;
  logic [2:0]      key_lane_q, key_lane_d;
  logic [5:0][2:0] rows_q, rows_d;
  logic [5:0]      offset_q, offset_d;
  logic [7:0]      score_q, score_d;
  logic            over_q, over_d;
  logic [2:0]      press_lane, spawn_lane, tgt;
  logic            found;
  logic [6:0]      sum;

  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1
  assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign spawn_lane = {1'b0, lfsr_q[1:0]} + 3'd1;

  always_comb begin
    case (key_press)
      4'b0001: press_lane = 3'd1;
      4'b0010: press_lane = 3'd2;
      4'b0100: press_lane = 3'd3;
      4'b1000: press_lane = 3'd4;
      default: press_lane = 3'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_pending_q) state_d = ISSUE;
      ISSUE:   if (all_drawing_done) state_d = RELEASE;
      RELEASE: state_d = UPDATE;
      UPDATE:  state_d = over_d ? OVER : IDLE;
      default: state_d = OVER;
    endcase
  end

  // A tick landing on the clear cycle re-arms; one landing on a still-pending tick is lost
  always_comb begin
    tick_pending_d = tick_pending_q;
    overrun_d      = overrun_q;
    if (state_q == IDLE && tick_pending_q) tick_pending_d = 1'b0;
    if (frame_tick && state_q != OVER) begin
      if (tick_pending_d) overrun_d = 1'b1;
      else                tick_pending_d = 1'b1;
    end
  end

  always_comb begin
    rows_d        = rows_q;
    offset_d      = offset_q;
    score_d       = score_q;
    over_d        = over_q;
    key_pending_d = key_pending_q;
    key_lane_d    = key_lane_q;
    found         = 1'b0;
    tgt           = 3'd0;
    sum           = 7'd0;
    if (state_q == UPDATE) begin
      key_pending_d = 1'b0;
      if (key_pending_q) begin
        for (int i = 0; i < 6; i++) begin
          if (rows_q[i] != 3'd0) begin
            found = 1'b1;
            tgt   = 3'(i);
          end
        end
        if (found) begin
          if (rows_q[tgt] == key_lane_q) begin
            rows_d[tgt] = 3'd0;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else begin
            over_d = 1'b1;
          end
        end
      end
      sum = {1'b0, offset_q} + 7'(STEP);
      if (sum < 7'(ROW_HEIGHT)) begin
        offset_d = sum[5:0];
      end else begin
        offset_d = 6'(sum - 7'(ROW_HEIGHT));
        if (rows_d[5] != 3'd0) over_d = 1'b1;
        rows_d = {rows_d[4:0], spawn_lane};
      end
    end
    if (state_q != OVER && !key_pending_q && press_lane != 3'd0) begin
      key_pending_d = 1'b1;
      key_lane_d    = press_lane;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      lfsr_q         <= LFSR_SEED;
      tick_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      key_pending_q  <= 1'b0;
      key_lane_q     <= 3'd0;
      rows_q         <= '0;
      offset_q       <= 6'd0;
      score_q        <= 8'd0;
      over_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      tick_pending_q <= tick_pending_d;
      overrun_q      <= overrun_d;
      key_pending_q  <= key_pending_d;
      key_lane_q     <= key_lane_d;
      rows_q         <= rows_d;
      offset_q       <= offset_d;
      score_q        <= score_d;
      over_q         <= over_d;
    end
  end

  assign draw_go       = (state_q == ISSUE);
  assign offset        = offset_q;
  assign lines         = rows_q;
  assign score         = score_q;
  assign game_over     = over_q;
  assign frame_overrun = overrun_q;
endmodule

// File: tb/tb_tile_scroll_control.sv
// Bench for tile_scroll_control: frame-level game model with LFSR spawn prediction and random draw delays.
module tb_tile_scroll_control;
  localparam int RH = 40;
  localparam int ST = 1;
  localparam logic [7:0] SEED = 8'hA5;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        all_drawing_done = 1'b0;
  logic [3:0]  key_press = 4'b0;
  logic        draw_go;
  logic [5:0]  offset;
  logic [17:0] lines;
  logic [7:0]  score;
  logic        game_over;
  logic        frame_overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int m_rows[6];
  int m_off, m_score, m_key;
  bit m_over, m_ovr, m_kp;

  tile_scroll_control #(.ROW_HEIGHT(RH), .STEP(ST), .LFSR_SEED(SEED)) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
    .all_drawing_done(all_drawing_done), .key_press(key_press),
    .draw_go(draw_go), .offset(offset), .lines(lines), .score(score),
    .game_over(game_over), .frame_overrun(frame_overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] l;
    l = SEED;
    for (int k = 0; k < n; k++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic logic [17:0] m_lines();
    logic [17:0] l;
    l = '0;
    for (int i = 0; i < 6; i++) l[3*i +: 3] = 3'(m_rows[i]);
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_rows[i] = 0;
    m_off = 0; m_score = 0; m_key = 0;
    m_over = 0; m_ovr = 0; m_kp = 0;
  endtask

  task automatic model_key(input logic [3:0] k);
    if (!m_over && !m_kp && $countones(k) == 1) begin
      m_kp = 1;
      for (int i = 0; i < 4; i++) if (k[i]) m_key = i + 1;
    end
  endtask

  task automatic model_update(input int spawn);
    int t, s;
    bit go;
    go = 0;
    if (m_kp) begin
      t = -1;
      for (int i = 5; i >= 0; i--) if (t < 0 && m_rows[i] != 0) t = i;
      if (t >= 0) begin
        if (m_rows[t] == m_key) begin
          m_rows[t] = 0;
          if (m_score < 255) m_score++;
        end else go = 1;
      end
      m_kp = 0;
    end
    s = m_off + ST;
    if (s < RH) m_off = s;
    else begin
      m_off = s - RH;
      if (m_rows[5] != 0) go = 1;
      for (int i = 5; i >= 1; i--) m_rows[i] = m_rows[i-1];
      m_rows[0] = spawn;
    end
    if (go) m_over = 1;
  endtask

  task automatic do_reset();
    @(negedge clock) resetn = 1'b0;
    model_reset();
    @(negedge clock) resetn = 1'b1;
  endtask

  // One full draw handshake; d = cycles of draw_go before done is raised
  task automatic run_frame(input logic [3:0] ka, input logic [3:0] kb, input int d,
                           input bit tick, input bit extra);
    int lat, hi, spawn;
    logic [7:0] l;
    lat = 0;
    if (tick) begin
      @(posedge clock); #1 frame_tick = 1'b1;
      @(posedge clock); #1 frame_tick = 1'b0;
      lat = 1;
    end
    while (draw_go !== 1'b1 && lat < 30) begin @(posedge clock); #1; lat++; end
    total++;
    if (draw_go !== 1'b1) begin
      bad++; $display("FAIL draw_go_rise got=%b want=1 (timeout)", draw_go);
      return;
    end
    if (tick) begin
      total++;
      if (lat != 2) begin bad++; $display("FAIL tick_latency got=%0d want=2", lat); end
    end
    hi = 1;
    for (int i = 0; i < d; i++) begin
      key_press = (i == 0) ? ka : (i == 1) ? kb : 4'b0;
      model_key(key_press);
      frame_tick = extra && (i == 1 || i == 3);
      total++;
      if (lines !== m_lines()) begin
        bad++; $display("FAIL lines_stable got=%h want=%h", lines, m_lines());
      end
      @(posedge clock); #1;
      if (draw_go === 1'b1) hi++;
    end
    key_press = 4'b0; frame_tick = 1'b0; all_drawing_done = 1'b1;
    @(posedge clock); #1 all_drawing_done = 1'b0;
    total++;
    if (draw_go !== 1'b0) begin bad++; $display("FAIL release_draw_go got=%b want=0", draw_go); end
    total++;
    if (hi != d + 1) begin bad++; $display("FAIL draw_go_len got=%0d want=%0d", hi, d + 1); end
    @(posedge clock); #1;
    l = lfsr_after(cyc);
    spawn = int'(l[1:0]) + 1;
    model_update(spawn);
    @(posedge clock); #1;
    total++;
    if (lines !== m_lines()) begin bad++; $display("FAIL frame_lines got=%h want=%h", lines, m_lines()); end
    total++;
    if (offset !== 6'(m_off)) begin bad++; $display("FAIL frame_offset got=%0d want=%0d", offset, m_off); end
    total++;
    if (score !== 8'(m_score)) begin bad++; $display("FAIL frame_score got=%0d want=%0d", score, m_score); end
    total++;
    if (game_over !== m_over) begin bad++; $display("FAIL frame_game_over got=%b want=%b", game_over, m_over); end
    total++;
    if (frame_overrun !== m_ovr) begin bad++; $display("FAIL frame_overrun got=%b want=%b", frame_overrun, m_ovr); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({draw_go, offset, lines, score, game_over, frame_overrun} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
                      {draw_go, offset, lines, score, game_over, frame_overrun});
    end
    @(negedge clock) resetn = 1'b1;
  endtask

  task automatic test_first_frame();
    do_reset();
    repeat (9) @(posedge clock);
    run_frame(4'b0, 4'b0, 6, 1, 0);
    total++;
    if (offset !== 6'd1 || lines !== 18'd0) begin
      bad++; $display("FAIL first_frame got=off%0d/%h want=off1/0", offset, lines);
    end
  endtask

  task automatic test_scroll_wrap();
    for (int f = 0; f < 39; f++) run_frame(4'b0, 4'b0, $urandom_range(2, 7), 1, 0);
    total++;
    if (offset !== 6'd0) begin bad++; $display("FAIL wrap_offset got=%0d want=0", offset); end
    total++;
    if (lines[17:3] !== 15'd0 || lines[2:0] < 3'd1 || lines[2:0] > 3'd4 || game_over !== 1'b0) begin
      bad++; $display("FAIL wrap_spawn got=%h/%b want=row0 in 1..4 only, no game_over", lines, game_over);
    end
  endtask

  task automatic test_key_hit();
    logic [3:0] k;
    k = 4'b0001 << (m_rows[0] - 1);
    run_frame(k, 4'b0110, $urandom_range(2, 7), 1, 0);
    total++;
    if (score !== 8'd1 || lines !== 18'd0) begin
      bad++; $display("FAIL key_hit got=score%0d/%h want=score1/0", score, lines);
    end
  endtask

  task automatic test_wrong_key();
    int g, lane, w;
    logic [3:0] k;
    g = 0;
    while (m_rows[0] == 0 && g < 60) begin run_frame(4'b0, 4'b0, $urandom_range(2, 7), 1, 0); g++; end
    lane = m_rows[0];
    w = ((lane - 1 + $urandom_range(1, 3)) % 4) + 1;
    k = 4'b0001 << (w - 1);
    run_frame(k, 4'b0, $urandom_range(2, 7), 1, 0);
    total++;
    if (game_over !== 1'b1) begin bad++; $display("FAIL wrong_key got=%b want=1", game_over); end
  endtask

  task automatic test_over_frozen();
    bit seen;
    for (int f = 0; f < 3; f++) begin
      seen = 0;
      @(posedge clock); #1 frame_tick = 1'b1; key_press = 4'b0001;
      @(posedge clock); #1 frame_tick = 1'b0; key_press = 4'b0;
      repeat (8) begin @(posedge clock); #1; if (draw_go !== 1'b0) seen = 1; end
      total++;
      if (seen) begin bad++; $display("FAIL over_draw_go got=1 want=0"); end
      total++;
      if (score !== 8'(m_score) || lines !== m_lines() || offset !== 6'(m_off)) begin
        bad++; $display("FAIL over_frozen got=%0d/%h/%0d want=%0d/%h/%0d",
                        score, lines, offset, m_score, m_lines(), m_off);
      end
    end
  endtask

  task automatic test_wrap_over();
    int g;
    do_reset();
    g = 0;
    while (!m_over && g < 400) begin run_frame(4'b0, 4'b0, $urandom_range(2, 4), 1, 0); g++; end
    total++;
    if (game_over !== 1'b1 || g != 280) begin
      bad++; $display("FAIL wrap_over got=%b@%0d want=1@280", game_over, g);
    end
  endtask

  task automatic test_wrap_hit();
    int g;
    logic [3:0] k;
    do_reset();
    g = 0;
    while (!(m_rows[5] != 0 && m_off + ST >= RH) && g < 400) begin
      run_frame(4'b0, 4'b0, $urandom_range(2, 4), 1, 0); g++;
    end
    k = 4'b0001 << (m_rows[5] - 1);
    run_frame(k, 4'b0, $urandom_range(2, 7), 1, 0);
    total++;
    if (game_over !== 1'b0 || score !== 8'd1 || offset !== 6'd0) begin
      bad++; $display("FAIL wrap_hit got=go%b/score%0d/off%0d want=go0/score1/off0", game_over, score, offset);
    end
  endtask

  task automatic test_overrun();
    bit seen;
    m_ovr = 1;
    run_frame(4'b0, 4'b0, 6, 1, 1);
    run_frame(4'b0, 4'b0, $urandom_range(2, 7), 0, 0);
    seen = 0;
    repeat (15) begin @(posedge clock); #1; if (draw_go !== 1'b0) seen = 1; end
    total++;
    if (seen) begin bad++; $display("FAIL overrun_single_extra got=extra draw want=none"); end
  endtask

  task automatic test_async_reset();
    int w;
    bit seen;
    w = 0;
    @(posedge clock); #1 frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    while (draw_go !== 1'b1 && w < 20) begin @(posedge clock); #1; w++; end
    total++;
    if (draw_go !== 1'b1) begin bad++; $display("FAIL async_pre_draw got=%b want=1", draw_go); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({draw_go, offset, lines, score, game_over, frame_overrun} !== '0) begin
      bad++; $display("FAIL async_reset got=%h want=0",
                      {draw_go, offset, lines, score, game_over, frame_overrun});
    end
    model_reset();
    @(negedge clock) resetn = 1'b1;
    seen = 0;
    repeat (6) begin @(posedge clock); #1; if (draw_go !== 1'b0) seen = 1; end
    total++;
    if (seen) begin bad++; $display("FAIL async_idle got=draw_go want=0"); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_scroll_wrap();
    test_key_hit();
    test_wrong_key();
    test_over_frozen();
    test_wrap_over();
    test_wrap_hit();
    test_overrun();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tile_scroll_control.md
Name: tile_scroll_control

Overview:
- Game-state sequencer that sits directly upstream of the erase/draw sequencer.
- Owns the six tile rows (lane codes), the scroll offset, the score and game-over status.
- Once per frame tick it raises draw_go and holds it until drawing is complete. It then releases draw_go and advances the scroll, shifting rows and spawning a new row from an LFSR.
- Player key presses are latched and resolved against the lowest uncleared tile.

Parameters:
- ROW_HEIGHT, 40, pixel height of one row; legal range 2..63.
- STEP, 1, pixels scrolled per frame; must be less than ROW_HEIGHT.
- LFSR_SEED, 8'hA5, reset value of the spawn LFSR; must be nonzero.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- all_drawing_done  in  1  high while the draw sequencer is in its DONE state
- key_press  in  4  one-cycle pulses, one bit per lane; bit0 = lane 1
- draw_go  out  1  request to the draw sequencer; level, not pulse
- offset  out  6  scroll offset within a row, 0..ROW_HEIGHT-1
- lines  out  18  row lane codes; row i at [3i+2:3i]; 0 = empty row, 1..4 = tile lane; row 0 top, row 5 bottom
- score  out  8  tiles hit, saturating at 255
- game_over  out  1  sticky
- frame_overrun  out  1  sticky; a tick was lost

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-draw):
  - draw_go=0, offset=0, lines=0, score=0, game_over=0, frame_overrun=0.
  - lfsr=LFSR_SEED, tick_pending=0, key_pending=0, state=IDLE.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every clock, in all states.
  - Spawn lane = lfsr[1:0]+1, sampled in the UPDATE cycle.
- tick_pending:
  - Set by frame_tick; cleared on IDLE->ISSUE.
  - frame_tick while tick_pending is already 1 -> frame_overrun=1 and the tick is dropped.
  - frame_tick in the same cycle as the clear re-arms tick_pending.
- key_pending:
  - Capture: a key_press with exactly one bit set, arriving while key_pending=0, is latched (lane number).
  - Ignored: zero or multiple bits set, or any key_press while key_pending=1.
  - Consumed only in UPDATE.
- FSM:
  - IDLE: draw_go=0. tick_pending -> ISSUE.
  - ISSUE: draw_go=1. all_drawing_done=1 -> RELEASE.
  - RELEASE: draw_go=0 for exactly one cycle, so the sequencer leaves DONE -> UPDATE.
  - UPDATE: one cycle, performs the ordered update below -> IDLE, or -> OVER if game_over is set.
  - OVER: draw_go=0; all ticks and keys ignored; lines/offset/score frozen; exit only via reset.
- draw_go timing:
  - Rises the cycle after IDLE sees tick_pending.
  - Falls the cycle after all_drawing_done is sampled high.
  - Minimum tick-to-draw_go latency is 2 cycles.
  - Outputs lines/offset change only in UPDATE, so they are stable while draw_go=1.
- UPDATE ordered update (single cycle):
  1. Key resolve:
     - If key_pending: target = highest-index nonzero row (lowest on screen).
     - No target -> key discarded.
     - Target lane == key -> that row cleared to 0, score+1 (saturating).
     - Otherwise -> game_over=1.
     - key_pending cleared in all cases.
  2. Scroll:
     - sum = offset+STEP, computed in 7 bits.
     - If sum < ROW_HEIGHT: offset=sum.
     - Else: offset=sum-ROW_HEIGHT and rows shift, using row values after step 1.
     - Row shift: row5 nonzero -> game_over=1; row i <- row i-1 for i=5..1; row0 <- spawn lane.
  3. If game_over was set in either step, the next state is OVER. The update still commits, so the display shows the final frame.
- A key hit and a row wrap in the same UPDATE are legal: a hit on row5 prevents the game-over that the wrap would otherwise cause.

Test Plan:
1. Reset, frame_tick at cycle 10, all_drawing_done driven high 6 cycles after draw_go rises -> draw_go high from cycle 12 until 1 cycle after done sampled; one RELEASE cycle; offset 0->1; lines unchanged; state back to IDLE.
2. 40 frames from reset with no keys -> offset returns to 0 on the 40th UPDATE; row0 equals the predicted LFSR spawn lane (1..4); rows 1..5 shift by one; game_over=0.
3. Preload via frames so the lowest tile is lane 3; pulse key_press=4'b0100 during ISSUE -> at UPDATE that row becomes 0, score=1; key_press=4'b0110 in the same frame ignored.
4. Wrong key (4'b0001 while the lowest tile is lane 3) -> game_over=1 after UPDATE; subsequent frame_ticks give draw_go=0 and a frozen score.
5. Let a tile reach row5 with no key, run to wrap -> game_over=1; repeat with the correct key latched in the wrap frame -> row cleared, score+1, no game_over.
6. Two extra frame_ticks during ISSUE -> exactly one extra draw cycle follows and frame_overrun=1; assert resetn low mid-ISSUE -> draw_go=0 and all state reset in the same cycle, without waiting for a clock edge.
